// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and lock FSM state encoding.
package vga_pkg;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam logic [9:0] CNT_MAX = 10'd1023;
    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} lock_state_t;
endpackage

// File: rtl/vga_period_meter.sv
// vga_period_meter: saturating edge-to-edge counter with latched period.
module vga_period_meter (
    input  logic       pclk,
    input  logic       reset,
    input  logic       mark,
    input  logic       inc,
    output logic [9:0] count,
    output logic [9:0] period
);
    import vga_pkg::*;
    // count stays 0 until the first mark, which flags an unmeasured period
    always_ff @(posedge pclk) begin
        if (reset) begin
            count  <= '0;
            period <= '0;
        end else if (mark) begin
            count  <= 10'd1;
            period <= count;
        end else if (inc && count != '0 && count != CNT_MAX) begin
            count <= count + 10'd1;
        end
    end
endmodule

// File: rtl/vga_rx_capture.sv
// vga_rx_capture: VGA receiver with timing measurement, lock tracking and pixel capture.
module vga_rx_capture #(
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [23:0] pix_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        pix_valid,
    output logic        frame_start,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        sync_err
);
    import vga_pkg::*;
    localparam logic [9:0] H_REF = 10'(H_TOTAL);
    localparam logic [9:0] V_REF = 10'(V_TOTAL);
    logic        hsync_s1, vsync_s1, hsync_d, vsync_d, valid_s1;
    logic [23:0] rgb_s1;
    logic        h_fall, v_fall, h_bad, v_bad, h_sat, line_hit, err_nx, fs_nx;
    logic [9:0]  h_cnt, v_cnt, x_cnt, y_cnt, x_cur, y_cur;
    lock_state_t state, state_nx;
    always_ff @(posedge pclk) begin
        if (reset) begin
            hsync_s1 <= 1'b1;
            vsync_s1 <= 1'b1;
            hsync_d  <= 1'b1;
            vsync_d  <= 1'b1;
            valid_s1 <= 1'b0;
            rgb_s1   <= '0;
        end else begin
            hsync_s1 <= hsync;
            vsync_s1 <= vsync;
            hsync_d  <= hsync_s1;
            vsync_d  <= vsync_s1;
            valid_s1 <= valid;
            rgb_s1   <= {vga_r, vga_g, vga_b};
        end
    end
    assign h_fall = !hsync_s1 && hsync_d;
    assign v_fall = !vsync_s1 && vsync_d;
    vga_period_meter u_line (
        .pclk(pclk), .reset(reset), .mark(h_fall), .inc(1'b1), .count(h_cnt), .period(line_len)
    );
    vga_period_meter u_frame (
        .pclk(pclk), .reset(reset), .mark(v_fall), .inc(h_fall), .count(v_cnt), .period(frame_lines)
    );
    // a zero count means no line start has been seen yet, so that length is not judged
    assign h_bad  = h_fall && h_cnt != '0 && h_cnt != H_REF;
    assign v_bad  = v_cnt != V_REF;
    assign h_sat  = h_cnt == CNT_MAX;
    assign locked = state == LOCKED;
    always_comb begin
        err_nx   = locked && (h_bad || (v_fall && v_bad) || h_sat);
        fs_nx    = v_fall && state != SEARCH;
        state_nx = state == SEARCH ? (v_fall ? CHECK : SEARCH) :
                   state == CHECK  ? (h_bad || (v_fall && v_bad) ? SEARCH : v_fall ? LOCKED : CHECK) :
                   state == LOCKED ? (err_nx ? SEARCH : LOCKED) : SEARCH;
    end
    assign x_cur = h_fall ? '0 : x_cnt;
    assign y_cur = v_fall ? '0 : (h_fall && line_hit && y_cnt != CNT_MAX) ? y_cnt + 10'd1 : y_cnt;
    always_ff @(posedge pclk) begin
        if (reset) begin
            state       <= SEARCH;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_hit    <= 1'b0;
            pix_data    <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            pix_valid   <= 1'b0;
        end else begin
            state       <= state_nx;
            sync_err    <= err_nx;
            frame_start <= fs_nx;
            x_cnt       <= valid_s1 && x_cur != CNT_MAX ? x_cur + 10'd1 : x_cur;
            y_cnt       <= y_cur;
            line_hit    <= h_fall ? valid_s1 : line_hit || valid_s1;
            pix_data    <= rgb_s1;
            x_pos       <= x_cur;
            y_pos       <= y_cur;
            pix_valid   <= valid_s1 && locked;
        end
    end
endmodule

// File: tb/tb_vga_rx_capture.sv
// tb_vga_rx_capture: frame-table driven checks of lock tracking plus random-pixel capture model.
module tb_vga_rx_capture;
    localparam int HT = 40, VT = 20, HS = 4, VS = 2, XA = 8, XW = 24, YA = 4, YW = 12;
    logic        pclk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [23:0] pix_data;
    logic [9:0]  x_pos, y_pos, line_len, frame_lines;
    logic        pix_valid, frame_start, locked, sync_err;
    int checks = 0, errors = 0, n_pix = 0, n_fs = 0, n_se = 0;
    typedef struct { bit v; int x; int y; logic [23:0] d; } pix_t;
    typedef struct { int bad_line; int bad_len; int rst_line; int lock_lines; int ll0; int fl; int fs; int se; } frame_t;
    pix_t   e1 = '{0, 0, 0, 24'd0}, e2 = '{0, 0, 0, 24'd0};
    frame_t tbl[11];

    vga_rx_capture #(.H_TOTAL(HT), .V_TOTAL(VT)) dut (
        .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .pix_data(pix_data), .x_pos(x_pos),
        .y_pos(y_pos), .pix_valid(pix_valid), .frame_start(frame_start), .line_len(line_len),
        .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("reset_pix_data", 64'(pix_data), 64'd0);
        chk("reset_state", 64'({x_pos, y_pos, pix_valid, frame_start, locked, sync_err, line_len, frame_lines}), 64'd0);
    endtask

    // one pclk: sample outputs, compare against the pixel driven two cycles earlier, drive next inputs
    task automatic step(input logic h, input logic v, input logic en, input logic rst, input bit lk, input int x, input int y);
        pix_t cur;
        @(negedge pclk);
        chk("pix_valid", 64'(pix_valid), 64'(e2.v));
        if (e2.v) begin
            chk("x_pos", 64'(x_pos), 64'(e2.x));
            chk("y_pos", 64'(y_pos), 64'(e2.y));
            chk("pix_data", 64'(pix_data), 64'(e2.d));
        end
        n_pix += int'(pix_valid);
        n_fs  += int'(frame_start);
        n_se  += int'(sync_err);
        e2 = e1;
        if (rst) e2.v = 1'b0;
        cur.d = 24'($urandom);
        cur.v = en && lk && !rst;
        cur.x = x;
        cur.y = y;
        e1 = cur;
        hsync = h;
        vsync = v;
        valid = en;
        reset = rst;
        {vga_r, vga_g, vga_b} = cur.d;
    endtask

    task automatic run_line(input int line, input int len, input int lk_lines, input int rst_line, input int ll0);
        bit act, rst;
        for (int c = 0; c < len; c++) begin
            if (c == 20) begin
                chk("locked", 64'(locked), 64'(line < lk_lines));
                if (line == 0) chk("line_len_line0", 64'(line_len), 64'(ll0));
            end
            if (line == rst_line && c == 23) chk_reset();
            act = line >= YA && line < YA + YW && c >= XA && c < XA + XW;
            rst = line == rst_line && c >= 21 && c <= 23;
            step(c >= HS, line >= VS, act, rst, line < lk_lines, c - XA, line - YA);
        end
    endtask

    task automatic run_frame(input frame_t f);
        int a;
        n_pix = 0;
        n_fs  = 0;
        n_se  = 0;
        for (int l = 0; l < VT; l++)
            run_line(l, l == f.bad_line ? f.bad_len : HT, f.lock_lines, f.rst_line, f.ll0);
        a = f.lock_lines < YA + YW ? f.lock_lines : YA + YW;
        a = a > YA ? a - YA : 0;
        chk("frame_lines", 64'(frame_lines), 64'(f.fl));
        chk("line_len", 64'(line_len), 64'(HT));
        chk("frame_start_pulses", 64'(n_fs), 64'(f.fs));
        chk("sync_err_pulses", 64'(n_se), 64'(f.se));
        chk("pix_valid_count", 64'(n_pix), 64'(a * XW));
    endtask

    initial begin
        tbl[0]  = '{-1,  0, -1,  0,    0,  0, 0, 0};
        tbl[1]  = '{-1,  0, -1, 20,   40, 20, 1, 0};
        tbl[2]  = '{-1,  0, -1, 20,   40, 20, 1, 0};
        tbl[3]  = '{ 7, 39, -1,  8,   40, 20, 1, 1};
        tbl[4]  = '{-1,  0, -1,  0,   40, 20, 0, 0};
        tbl[5]  = '{-1,  0, -1, 20,   40, 20, 1, 0};
        tbl[6]  = '{-1,  0, -1,  0, 1023, 20, 0, 0};
        tbl[7]  = '{-1,  0, -1, 20,   40, 20, 1, 0};
        tbl[8]  = '{-1,  0,  2,  3,   40,  0, 1, 0};
        tbl[9]  = '{-1,  0, -1,  0,   40,  0, 0, 0};
        tbl[10] = '{-1,  0, -1, 20,   40, 20, 1, 0};
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        chk_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            // hsync stuck high while locked: line counter saturates and lock drops
            if (i == 6) begin
                n_se = 0;
                repeat (1100) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                chk("stuck_hsync_sync_err", 64'(n_se), 64'd1);
                chk("stuck_hsync_locked", 64'(locked), 64'd0);
            end
            run_frame(tbl[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_rx_capture.md
VGA_RX_CAPTURE -- requirements
Module: vga_rx_capture

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning expected pclk cycles per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning expected lines per frame.
REQ-003 SHALL have port pclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port hsync, input, 1, line sync; active-low pulse, and its falling edge marks line start.
REQ-006 SHALL have port vsync, input, 1, frame sync; active-low pulse, and its falling edge marks frame start.
REQ-007 SHALL have port valid, input, 1, active-video flag.
REQ-008 SHALL have ports vga_r, vga_g and vga_b, input, 8 each, pixel colour.
REQ-009 SHALL have port pix_data, output, 24, captured colour as {r,g,b}.
REQ-010 SHALL have ports x_pos and y_pos, output, 10 each, active-pixel coordinate of pix_data.
REQ-011 SHALL have port pix_valid, output, 1, qualifier for pix_data, x_pos and y_pos.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse per detected frame start.
REQ-013 SHALL have ports line_len and frame_lines, output, 10 each, last measured line period and frame period.
REQ-014 SHALL have port locked, output, 1, timing matches H_TOTAL and V_TOTAL.
REQ-015 SHALL have port sync_err, output, 1, one-cycle pulse on loss of lock.

Function
REQ-016 SHALL register all inputs once (stage S1) and detect sync falling edges as S1 low and previous S1 high.
REQ-017 SHALL present pix_data, x_pos, y_pos and pix_valid registered, 2 pclk after the inputs are sampled.
REQ-018 SHALL count h_cnt from 1 on the hsync-fall cycle and increment it every pclk, saturating at 1023.
REQ-019 SHALL, at the next hsync fall, load line_len with h_cnt and restart h_cnt at 1.
REQ-020 SHALL count hsync falls since the last vsync fall in v_cnt (10 bits, saturating), load frame_lines at each vsync fall, and restart v_cnt at 1.
REQ-021 SHALL reset x_pos to 0 at each hsync fall and increment it after each valid pixel, saturating at 1023.
REQ-022 SHALL increment y_pos at an hsync fall only if the previous line had at least one valid pixel.
REQ-023 SHALL reset y_pos to 0 at a vsync fall; vsync fall takes priority over simultaneous hsync fall.
REQ-024 SHALL drive pix_valid = S1 valid AND locked, so no pixel is qualified while unlocked.
REQ-025 SHALL run lock FSM states SEARCH, CHECK and LOCKED.
REQ-026 SHALL move SEARCH->CHECK on a vsync fall; otherwise SEARCH holds.
REQ-027 SHALL handle CHECK as follows: every hsync fall with line_len != H_TOTAL goes to SEARCH; at the next vsync fall, frame_lines == V_TOTAL goes to LOCKED, else SEARCH.
REQ-028 SHALL make LOCKED->SEARCH on a wrong line_len at an hsync fall, on a wrong frame_lines at a vsync fall, or when h_cnt saturates, and pulse sync_err for 1 cycle.
REQ-029 SHALL drive locked high only in LOCKED.
REQ-030 SHALL pulse frame_start at every vsync fall while in CHECK or LOCKED.
REQ-031 SHALL ignore line_len measured before the first hsync fall after reset (first-line exemption).

Reset
REQ-032 SHALL on reset: FSM=SEARCH; h_cnt, v_cnt, x_pos, y_pos, line_len and frame_lines = 0; pix_data = 0; pix_valid, frame_start, locked and sync_err = 0; S1 syncs = 1 (idle high).
REQ-033 SHALL, on reset asserted mid-frame, take effect on the next pclk edge with no sync_err pulse.

Structure
REQ-034 SHALL take H_TOTAL, V_TOTAL, H_ACTIVE=640, V_ACTIVE=480 and the FSM state encodings from shared package vga_pkg.
REQ-035 SHALL implement period measurement as sub-module vga_period_meter (edge in, saturating count, latched period), instantiated for line and frame.

Verification
REQ-036 SHALL cover standard 640x480 timing for 3 frames -> locked rises at the 2nd vsync fall; line_len=800; frame_lines=525; no sync_err.
REQ-037 SHALL cover the locked first active pixel of a frame -> pix_valid with x_pos=0, y_pos=0, pix_data = input value 2 pclk later.
REQ-038 SHALL cover the locked last active pixel -> x_pos=639, y_pos=479; 307200 pix_valid pulses per frame.
REQ-039 SHALL cover one line shortened to 799 while locked -> sync_err 1 cycle, locked=0, pix_valid=0 until relock.
REQ-040 SHALL cover hsync held high for more than 1023 pclk -> h_cnt saturates at 1023; sync_err; SEARCH.
REQ-041 SHALL cover reset asserted mid-frame then released -> all outputs 0; relock after 1 full frame.
